line_memory_arbiter: RTL and testbench

- Shares the single-port 128-bit line memory (64 lines, 16 byte-enables, synchronous read) between two requesters: the instruction-cache refill port (read-only) and the data-cache refill/write-back port (read/write).
- Sits between both caches and the memory macro.
- Latches each request, sequences the memory access cycle-by-cycle, returns the line and pulses a one-cycle ack.
- Round-robin arbitration when both requesters ask in the same cycle.

---
 rtl/line_memory_arbiter.sv | 110 +++++++++++
 tb/tb_line_memory_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory_arbiter.sv
// Arbitrates a single-port line memory between the instruction refill port (read-only)
// and the data refill/write-back port; round-robin on ties, all outputs registered.
module line_memory_arbiter #(
   parameter int ADDR_WIDTH  = 6,
   parameter int LINE_WIDTH  = 128,
   parameter int MEM_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic [LINE_WIDTH-1:0]   i_rdata,
   output logic                    i_ack,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [LINE_WIDTH-1:0]   d_wdata,
   input  logic [LINE_WIDTH/8-1:0] d_byteena,
   output logic [LINE_WIDTH-1:0]   d_rdata,
   output logic                    d_ack,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [LINE_WIDTH/8-1:0] mem_byteena,
   output logic [LINE_WIDTH-1:0]   mem_data,
   output logic                    mem_wren,
   input  logic [LINE_WIDTH-1:0]   mem_q,
   output logic                    busy
);
   localparam logic [2:0] LAST_COUNT = 3'(MEM_LATENCY);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t     state;
   logic [2:0] count;
   logic       last_d;
   logic       grant_d;
   logic       grant_we;
   logic       take_d;
   logic       take_we;

   // Handshake: req is a level held until its one-cycle ack and is only sampled in
   // IDLE, so a request raised while busy simply waits for the next IDLE cycle.
   always_comb begin
      take_d  = d_req && (!i_req || !last_d);
      take_we = take_d && d_we;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         count       <= '0;
         last_d      <= 1'b0;
         grant_d     <= 1'b0;
         grant_we    <= 1'b0;
         i_rdata     <= '0;
         i_ack       <= 1'b0;
         d_rdata     <= '0;
         d_ack       <= 1'b0;
         mem_address <= '0;
         mem_byteena <= '0;
         mem_data    <= '0;
         mem_wren    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         i_ack    <= 1'b0;
         d_ack    <= 1'b0;
         mem_wren <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  grant_d     <= take_d;
                  grant_we    <= take_we;
                  last_d      <= take_d;
                  mem_address <= take_d ? d_addr : i_addr;
                  mem_byteena <= take_we ? d_byteena : '1;
                  if (take_d) mem_data <= d_wdata;
                  mem_wren    <= take_we;
                  count       <= '0;
                  busy        <= 1'b1;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (grant_we) begin
                  mem_byteena <= '0;
                  d_ack       <= 1'b1;
                  state       <= DONE;
               end else if (count == LAST_COUNT) begin
                  // Read data is valid on the last ACCESS cycle; capture on its closing edge.
                  if (grant_d) begin
                     d_rdata <= mem_q;
                     d_ack   <= 1'b1;
                  end else begin
                     i_rdata <= mem_q;
                     i_ack   <= 1'b1;
                  end
                  mem_byteena <= '0;
                  state       <= DONE;
               end else begin
                  count <= count + 3'd1;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_line_memory_arbiter.sv
// Bench for line_memory_arbiter: directed cases plus random traffic checked against a
// transaction-level model (memory image, grant alternation, latency formulas).
module tb_line_memory_arbiter;
   localparam int AW  = 6;
   localparam int LW  = 128;
   localparam int BW  = LW / 8;
   localparam int LAT = 1;

   typedef struct packed {
      logic          is_d;
      logic          we;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      logic [BW-1:0] be;
   } txn_t;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic          i_req, d_req, d_we;
   logic [AW-1:0] i_addr, d_addr;
   logic [LW-1:0] d_wdata;
   logic [BW-1:0] d_byteena;
   logic [LW-1:0] i_rdata, d_rdata, mem_data, mem_q;
   logic          i_ack, d_ack, mem_wren, busy;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_byteena;

   logic          i_req3;
   logic [AW-1:0] i_addr3;
   logic [LW-1:0] i_rdata3, d_rdata3, mem_data3, mem_q3;
   logic          i_ack3, d_ack3, mem_wren3, busy3;
   logic [AW-1:0] mem_address3;
   logic [BW-1:0] mem_byteena3;

   line_memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byteena(d_byteena), .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_address(mem_address), .mem_byteena(mem_byteena), .mem_data(mem_data),
      .mem_wren(mem_wren), .mem_q(mem_q), .busy(busy)
   );

   line_memory_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req3), .i_addr(i_addr3), .i_rdata(i_rdata3), .i_ack(i_ack3),
      .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
      .d_byteena('0), .d_rdata(d_rdata3), .d_ack(d_ack3),
      .mem_address(mem_address3), .mem_byteena(mem_byteena3), .mem_data(mem_data3),
      .mem_wren(mem_wren3), .mem_q(mem_q3), .busy(busy3)
   );

   // memory macros: one-cycle and three-cycle synchronous read
   logic [LW-1:0] mem [64];
   logic [LW-1:0] mem3 [64];
   logic [LW-1:0] q_pipe, p0, p1, p2;
   always @(posedge clk) begin
      q_pipe <= mem[mem_address];
      if (mem_wren)
         for (int b = 0; b < BW; b++)
            if (mem_byteena[b]) mem[mem_address][8*b +: 8] = mem_data[8*b +: 8];
   end
   assign mem_q = q_pipe;
   always @(posedge clk) begin
      p0 <= mem3[mem_address3];
      p1 <= p0;
      p2 <= p1;
   end
   assign mem_q3 = p2;

   // reference model state
   logic [LW-1:0] init_line [64];
   logic [LW-1:0] ref_mem [64];
   logic [LW-1:0] ref_i, ref_d;
   logic          ref_last_d;
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int lat(input txn_t t);
      return (t.is_d && t.we) ? 2 : LAT + 2;
   endfunction

   task automatic model_apply(input txn_t t);
      if (t.is_d && t.we) begin
         for (int b = 0; b < BW; b++)
            if (t.be[b]) ref_mem[t.addr][8*b +: 8] = t.wdata[8*b +: 8];
      end else if (t.is_d) ref_d = ref_mem[t.addr];
      else ref_i = ref_mem[t.addr];
      ref_last_d = t.is_d;
   endtask

   function automatic txn_t mk(input logic is_d, input logic we, input logic [AW-1:0] addr,
                               input logic [LW-1:0] wdata, input logic [BW-1:0] be);
      txn_t t;
      t.is_d = is_d; t.we = is_d & we; t.addr = addr; t.wdata = wdata; t.be = be;
      return t;
   endfunction

   function automatic txn_t rand_txn(input logic is_d);
      return mk(is_d, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                {$urandom(), $urandom(), $urandom(), $urandom()}, BW'($urandom_range(0, 65535)));
   endfunction

   // driver tasks
   task automatic drive(input txn_t t);
      if (t.is_d) begin
         d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_byteena = t.be;
      end else begin
         i_req = 1'b1; i_addr = t.addr;
      end
   endtask

   task automatic do_single(input txn_t t);
      int got = 0;
      int wren_cycles = 0;
      logic [BW-1:0] exp_be;
      exp_be = (t.is_d && t.we) ? t.be : {BW{1'b1}};
      drive(t);
      model_apply(t);
      for (int k = 1; k <= 12 && got == 0; k++) begin
         step();
         if (k == 1) begin
            check("access_addr", mem_address, t.addr);
            check("access_byteena", mem_byteena, exp_be);
         end
         if (mem_wren) wren_cycles++;
         check("busy", busy, 1);
         if (t.is_d ? d_ack : i_ack) got = k;
      end
      check("ack_cycle", got, lat(t));
      check("other_ack", t.is_d ? i_ack : d_ack, 0);
      check("wren_cycles", wren_cycles, (t.is_d && t.we) ? 1 : 0);
      check("done_byteena", mem_byteena, 0);
      check("i_rdata", i_rdata, ref_i);
      check("d_rdata", d_rdata, ref_d);
      if (t.is_d) d_req = 1'b0; else i_req = 1'b0;
      step();
      check("idle_busy", busy, 0);
   endtask

   task automatic do_pair(input txn_t ti, input txn_t td);
      int gi = 0;
      int gd = 0;
      int ei, ed;
      logic [LW-1:0] exp_i, exp_d;
      txn_t w, l;
      if (ref_last_d) begin w = ti; l = td; end else begin w = td; l = ti; end
      model_apply(w);
      model_apply(l);
      exp_i = ref_i;
      exp_d = ref_d;
      if (w.is_d) begin ed = lat(w); ei = ed + 1 + lat(l); end
      else begin ei = lat(w); ed = ei + 1 + lat(l); end
      drive(ti);
      drive(td);
      for (int k = 1; k <= 30 && (gi == 0 || gd == 0); k++) begin
         step();
         if (i_ack && gi == 0) begin
            gi = k;
            check("pair_i_rdata", i_rdata, exp_i);
            i_req = 1'b0;
         end
         if (d_ack && gd == 0) begin
            gd = k;
            check("pair_d_rdata", d_rdata, exp_d);
            d_req = 1'b0;
         end
      end
      check("pair_i_ack_cycle", gi, ei);
      check("pair_d_ack_cycle", gd, ed);
      step();
      check("pair_idle_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t t;
      int got;
      logic [AW-1:0] a;
      i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_byteena = '0;
      i_req3 = 0; i_addr3 = '0;
      ref_i = '0; ref_d = '0; ref_last_d = 1'b0;
      for (int k = 0; k < 64; k++) begin
         init_line[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (k == 5) init_line[k] = {8{16'hA5A5}};
         mem[k] = init_line[k];
         mem3[k] = init_line[k];
         ref_mem[k] = init_line[k];
      end

      // reset state
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_i_ack", i_ack, 0);
      check("rst_d_ack", d_ack, 0);
      check("rst_mem_wren", mem_wren, 0);
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_byteena", mem_byteena, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      reset_n = 1'b1;
      step();

      // first tie after reset goes to D, then fairness over further pairs
      do_pair(mk(0, 0, 6'd9, '0, '0), mk(1, 0, 6'd5, '0, '0));
      check("line5_value", d_rdata, {8{16'hA5A5}});
      for (int n = 0; n < 4; n++) do_pair(rand_txn(0), rand_txn(1));

      // single read, partial write to the top line, read back
      do_single(mk(1, 0, 6'd5, '0, '0));
      do_single(mk(1, 1, 6'd63, 128'h0102030405060708090a0b0c0d0e0f10, 16'h000F));
      do_single(mk(1, 0, 6'd63, '0, '0));
      check("line63_low", d_rdata[31:0], 32'h0d0e0f10);

      // write with no byte enables leaves the line intact
      do_single(mk(1, 1, 6'd7, {4{32'hDEADBEEF}}, 16'h0000));
      do_single(mk(1, 0, 6'd7, '0, '0));
      do_single(mk(0, 0, 6'd12, '0, '0));

      // three-cycle memory: i_addr change after grant is ignored
      a = AW'($urandom_range(0, 63));
      i_req3 = 1'b1; i_addr3 = a;
      step();
      i_addr3 = a ^ 6'h2A;
      check("lat3_addr_c1", mem_address3, a);
      got = 0;
      for (int k = 2; k <= 12 && got == 0; k++) begin
         step();
         if (i_ack3) got = k;
      end
      check("lat3_ack_cycle", got, 5);
      check("lat3_addr_held", mem_address3, a);
      check("lat3_i_rdata", i_rdata3, init_line[a]);
      i_req3 = 1'b0;
      step();

      // reset during the second ACCESS cycle of a read discards the transaction
      t = mk(1, 0, AW'($urandom_range(0, 63)), '0, '0);
      drive(t);
      step();
      step();
      reset_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_mem_wren", mem_wren, 0);
      check("midrst_mem_address", mem_address, 0);
      check("midrst_d_rdata", d_rdata, 0);
      step();
      check("midrst_no_ack", d_ack, 0);
      reset_n = 1'b1;
      ref_last_d = 1'b0; ref_i = '0; ref_d = '0;
      do_single(t);

      // random traffic
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0: do_single(rand_txn(0));
            1: do_single(rand_txn(1));
            default: do_pair(rand_txn(0), rand_txn(1));
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
